sync_fifo_prog: RTL and testbench

Parametrised successor to the single-channel synchronous FIFO. Adds:
- runtime-programmable almost-full/almost-empty levels
- an exact fill count
- a compile-time first-word-fall-through (FWFT) read mode
- separate sticky overflow and underflow error flags with software clear

It sits between a producer and a consumer in the same clock domain as the general-purpose buffering primitive.

---
 rtl/sync_fifo_prog.sv | 121 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - synchronous FIFO with programmable levels, FWFT option, sticky errors; optional SYNC_FIFO_PROG_PEAK_EN high-watermark
module sync_fifo_prog #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int FWFT  = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic [CW-1:0]    af_level,
  input  logic [CW-1:0]    ae_level,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
`ifdef SYNC_FIFO_PROG_PEAK_EN
  ,
  output logic [CW-1:0]    peak_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [CW-1:0]    count_nx;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_level);
  assign almost_empty = (count <= ae_level);
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;

  // Occupancy after this edge: simultaneous accepted read and write cancel out
  always_comb begin
    count_nx = count;
    if (wr_acc && !rd_acc) begin
      count_nx = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nx = count - CW'(1);
    end
  end

  // Pointers and occupancy counter; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Sticky error flags; a fresh error takes priority over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)       overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en && empty)      underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout       = mem[rd_ptr];
      assign dout_valid = !empty;
    end else begin : g_std
      // Registered read port: word and its valid strobe appear the cycle after the pop
      always_ff @(posedge clk) begin
        if (rst) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= rd_acc;
          if (rd_acc) dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

`ifdef SYNC_FIFO_PROG_PEAK_EN
  // High-watermark of occupancy; a new peak in the clearing cycle is still captured
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_count <= '0;
    end else if (count_nx > peak_count) begin
      peak_count <= count_nx;
    end else if (err_clr) begin
      peak_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized and directed bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  din = '0;
  logic [CW-1:0] af_level = '0;
  logic [CW-1:0] ae_level = '0;

  logic [W-1:0]  s_dout, f_dout;
  logic          s_dv, f_dv;
  logic [CW-1:0] s_count, f_count;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
`ifdef SYNC_FIFO_PROG_PEAK_EN
  logic [CW-1:0] s_peak, f_peak;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_dv;
  logic         m_ovf;
  logic         m_udf;
  int           m_peak;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .af_level(af_level), .ae_level(ae_level),
    .count(s_count), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr)
`ifdef SYNC_FIFO_PROG_PEAK_EN
    , .peak_count(s_peak)
`endif
  );

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .af_level(af_level), .ae_level(ae_level),
    .count(f_count), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr)
`ifdef SYNC_FIFO_PROG_PEAK_EN
    , .peak_count(f_peak)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, using the inputs present before the edge
  task automatic model_step();
    int n;
    n = q.size();
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_peak = 0;
    end else begin
      m_dv = 1'b0;
      if (rd_en && n > 0) begin
        m_dout = q.pop_front();
        m_dv   = 1'b1;
      end
      if (wr_en && n < D) q.push_back(din);
      if (wr_en && n == D) m_ovf = 1'b1;
      else if (err_clr)    m_ovf = 1'b0;
      if (rd_en && n == 0) m_udf = 1'b1;
      else if (err_clr)    m_udf = 1'b0;
      if (q.size() > m_peak) m_peak = q.size();
      else if (err_clr)      m_peak = 0;
    end
  endtask

  task automatic check_flags();
    int n;
    n = q.size();
    check("s_full",  s_full,  n == D);
    check("s_empty", s_empty, n == 0);
    check("s_af",    s_af,    n >= int'(af_level));
    check("s_ae",    s_ae,    n <= int'(ae_level));
    check("f_full",  f_full,  n == D);
    check("f_empty", f_empty, n == 0);
    check("f_af",    f_af,    n >= int'(af_level));
    check("f_ae",    f_ae,    n <= int'(ae_level));
  endtask

  task automatic check_all();
    check("s_count", s_count, q.size());
    check("f_count", f_count, q.size());
    check_flags();
    check("s_ovf", s_ovf, m_ovf);
    check("s_udf", s_udf, m_udf);
    check("f_ovf", f_ovf, m_ovf);
    check("f_udf", f_udf, m_udf);
    check("s_dv",   s_dv,   m_dv);
    check("s_dout", s_dout, m_dout);
    check("f_dv",   f_dv,   q.size() != 0);
    if (q.size() != 0) check("f_dout", f_dout, q[0]);
`ifdef SYNC_FIFO_PROG_PEAK_EN
    check("s_peak", s_peak, m_peak);
    check("f_peak", f_peak, m_peak);
`endif
  endtask

  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    rst     = 1'b0;
    err_clr = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 32'hdead, 1'b1);
  endtask

  initial begin
    int bias;
    m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_peak = 0;

    // Reset state with af_level 0 so almost_full is expected high
    af_level = '0; ae_level = '0;
    do_reset();

    // Fill then drain in order
    for (int i = 0; i < D; i++) cyc(1'b1, i, 1'b0);
    for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Programmable levels, then a level change with no clock edge
    af_level = CW'(24); ae_level = CW'(8);
    #1 check_flags();
    for (int i = 0; i < 24; i++) cyc(1'b1, 32'h1000 + i, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
    af_level = CW'(4);
    #1 check_flags();

    // Overflow while full, simultaneous ops at full, then clear
    for (int i = 0; i < 24; i++) cyc(1'b1, 32'h2000 + i, 1'b0);
    cyc(1'b1, 32'hbad0, 1'b0);
    cyc(1'b1, 32'hbad1, 1'b1);
    err_clr = 1'b1;
    cyc(1'b0, '0, 1'b0);

    // Underflow on empty, simultaneous ops at empty (no bypass)
    while (q.size() > 0) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 32'ha5, 1'b1);
    cyc(1'b0, '0, 1'b1);
    err_clr = 1'b1;
    cyc(1'b0, '0, 1'b0);

    // Wrap-around of pointers
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, i, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 100 + i, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);

    // Fall-through visibility and reset while occupied
    do_reset();
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b0, '0, 1'b1);
    do_reset();

    // Randomized traffic with drifting bias so both full and empty are reached
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) bias = (i / 60) % 3 == 0 ? 85 : ((i / 60) % 3 == 1 ? 15 : 50);
      if (i % 25 == 0) begin
        af_level = CW'($urandom_range(0, D));
        ae_level = CW'($urandom_range(0, D));
        #1 check_flags();
      end
      err_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 99) < bias, $urandom, $urandom_range(0, 99) < (100 - bias));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
